// File: rtl/sp_ram_pkg.sv
// sp_ram_param shared types and helpers.
// Imported by the interface, storage array and top.
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int lanes(int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/sp_ram_if.sv
// Request/valid bus of the single-port RAM.
// Master issues accesses, slave is the RAM.
interface sp_ram_if
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();

    logic                       req;
    logic                       we;
    logic [ADDR_W-1:0]          addr;
    logic [DATA_W-1:0]          wdata;
    logic [lanes(DATA_W)-1:0]   be;
    logic                       ready;
    logic                       rvalid;
    logic [DATA_W-1:0]          rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/sp_ram_array.sv
// Storage only: byte-lane writes, address-registered
// synchronous read.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [lanes(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]        dout
);

    localparam int NL = lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NL; i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <=
                        wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            addr_q <= addr;
        end
    end

    assign dout = mem[addr_q];

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port RAM: clear sequencer after
// reset, request qualification, optional output stage.
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 6,
    parameter int               DEPTH     = 64,
    parameter int               OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    sp_ram_if.slave  bus
);

    localparam int NL = lanes(DATA_W);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_nx;
    logic              in_range;
    logic              a_we;
    logic              a_re;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [NL-1:0]     a_be;
    logic [DATA_W-1:0] a_dout;
    logic              v1;
    logic              oor1;
    logic [DATA_W-1:0] d1;

    assign in_range = 32'(bus.addr) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= clr_ptr_nx;
        end
    end

    // The clear sequencer owns the array port until done.
    always_comb begin
        state_nx   = state;
        clr_ptr_nx = clr_ptr;
        a_we       = 1'b0;
        a_re       = 1'b0;
        a_addr     = bus.addr;
        a_wdata    = bus.wdata;
        a_be       = bus.be;
        unique case (state)
            ST_CLEAR: begin
                a_we       = ~rst;
                a_addr     = clr_ptr;
                a_wdata    = CLEAR_VAL;
                a_be       = '1;
                clr_ptr_nx = clr_ptr + 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                a_we = ~rst & bus.req & bus.we & in_range;
                a_re = ~rst & bus.req & ~bus.we;
            end
        endcase
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (a_we),
        .re    (a_re),
        .addr  (a_addr),
        .wdata (a_wdata),
        .be    (a_be),
        .dout  (a_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            oor1 <= 1'b0;
        end else begin
            v1   <= a_re;
            oor1 <= ~in_range;
        end
    end

    assign d1 = oor1 ? '0 : a_dout;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign bus.rvalid = v2;
            assign bus.rdata  = d2;
        end else begin : g_noreg
            // Holds the last read word so rdata stays stable.
            logic [DATA_W-1:0] hold;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold <= '0;
                end else if (v1) begin
                    hold <= d1;
                end
            end

            assign bus.rvalid = v1;
            assign bus.rdata  = v1 ? d1 : hold;
        end
    endgenerate

    assign bus.ready = (state == ST_READY);

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: a 64x8 latency-1 instance and a
// 48x32 latency-2 instance against a word-array model.
module tb_sp_ram_param;

    localparam logic [31:0] CV1 = 32'h5EED_C1EA;

    logic clk;
    logic rst0;
    logic rst1;
    int   cyc;
    int   total;
    int   bad;

    logic [7:0]  m0 [64];
    logic [31:0] m1 [48];
    logic [7:0]  due0 [int];
    logic [31:0] due1 [int];
    logic [7:0]  last0;
    logic [31:0] last1;
    bit          rdy0;
    bit          rdy1;

    sp_ram_if #(.DATA_W(8),  .ADDR_W(6)) b0 ();
    sp_ram_if #(.DATA_W(32), .ADDR_W(6)) b1 ();

    sp_ram_param #(
        .DATA_W(8), .ADDR_W(6), .DEPTH(64),
        .OUT_REG(0), .CLEAR_VAL(8'h00)
    ) u0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    sp_ram_param #(
        .DATA_W(32), .ADDR_W(6), .DEPTH(48),
        .OUT_REG(1), .CLEAR_VAL(CV1)
    ) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input bit r, input bit w,
                          input logic [5:0] a,
                          input logic [7:0] d,
                          input logic be);
        b0.req = r; b0.we = w; b0.addr = a;
        b0.wdata = d; b0.be = be;
        if (r && rdy0 && !rst0) begin
            if (w) begin
                if (be) m0[a] = d;
            end else begin
                due0[cyc + 1] = m0[a];
            end
        end
    endtask

    task automatic issue1(input bit r, input bit w,
                          input logic [5:0] a,
                          input logic [31:0] d,
                          input logic [3:0] be);
        b1.req = r; b1.we = w; b1.addr = a;
        b1.wdata = d; b1.be = be;
        if (r && rdy1 && !rst1) begin
            if (w) begin
                if (a < 48) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) m1[a][i*8 +: 8] = d[i*8 +: 8];
                end
            end else begin
                due1[cyc + 2] = (a < 48) ? m1[a] : 32'h0;
            end
        end
    endtask

    function automatic void exp0(output bit v,
                                 output logic [7:0] d);
        v = due0.exists(cyc);
        if (v) begin
            last0 = due0[cyc];
            due0.delete(cyc);
        end
        d = last0;
    endfunction

    function automatic void exp1(output bit v,
                                 output logic [31:0] d);
        v = due1.exists(cyc);
        if (v) begin
            last1 = due1[cyc];
            due1.delete(cyc);
        end
        d = last1;
    endfunction

    function automatic void model_reset();
        due0.delete(); due1.delete();
        last0 = '0; last1 = '0;
        rdy0 = 0; rdy1 = 0;
    endfunction

    function automatic void model_cleared();
        foreach (m0[i]) m0[i] = 8'h00;
        foreach (m1[i]) m1[i] = CV1;
        rdy0 = 1; rdy1 = 1;
    endfunction

    task automatic test_reset();
        rst0 = 1; rst1 = 1;
        model_reset();
        issue0(0, 0, '0, '0, '0);
        issue1(0, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) tick();
        total += 6;
        if (b0.ready !== 1'b0 || b1.ready !== 1'b0) begin
            $display("FAIL rst_ready got=%b/%b want=0/0",
                     b0.ready, b1.ready); bad++;
        end
        if (b0.rvalid !== 1'b0) begin
            $display("FAIL rst_rvalid0 got=%b want=0",
                     b0.rvalid); bad++;
        end
        if (b1.rvalid !== 1'b0) begin
            $display("FAIL rst_rvalid1 got=%b want=0",
                     b1.rvalid); bad++;
        end
        if (b0.rdata !== 8'h00) begin
            $display("FAIL rst_rdata0 got=%h want=00",
                     b0.rdata); bad++;
        end
        if (b1.rdata !== 32'h0) begin
            $display("FAIL rst_rdata1 got=%h want=0",
                     b1.rdata); bad++;
        end
        if (b0.ready !== b1.ready) begin
            $display("FAIL rst_ready_eq got=%b want=%b",
                     b0.ready, b1.ready); bad++;
        end
    endtask

    // Requests during CLEAR must be ignored.
    task automatic test_clear();
        rst0 = 0; rst1 = 0;
        for (int k = 1; k <= 70; k++) begin
            issue0(k <= 64, 1, 6'd0, 8'hFF, 1'b1);
            issue1(k <= 48, 0, 6'd0, '0, '0);
            tick();
            total += 4;
            if (b0.ready !== (k >= 64)) begin
                $display("FAIL clr_ready0 k=%0d got=%b want=%b",
                         k, b0.ready, k >= 64); bad++;
            end
            if (b1.ready !== (k >= 48)) begin
                $display("FAIL clr_ready1 k=%0d got=%b want=%b",
                         k, b1.ready, k >= 48); bad++;
            end
            if (b0.rvalid !== 1'b0) begin
                $display("FAIL clr_rvalid0 k=%0d got=%b want=0",
                         k, b0.rvalid); bad++;
            end
            if (b1.rvalid !== 1'b0) begin
                $display("FAIL clr_rvalid1 k=%0d got=%b want=0",
                         k, b1.rvalid); bad++;
            end
        end
        model_cleared();
    endtask

    task automatic test_sweep();
        bit          v0, v1;
        logic [7:0]  d0;
        logic [31:0] d1;
        for (int i = 0; i < 67; i++) begin
            issue0(i < 64, 0, 6'(i), '0, '0);
            issue1(i < 48, 0, 6'(i), '0, '0);
            tick();
            exp0(v0, d0);
            exp1(v1, d1);
            total += 2;
            if (b0.rvalid !== v0 || b0.rdata !== d0) begin
                $display("FAIL sweep0 i=%0d got=%b/%h want=%b/%h",
                         i, b0.rvalid, b0.rdata, v0, d0); bad++;
            end
            if (b1.rvalid !== v1 || b1.rdata !== d1) begin
                $display("FAIL sweep1 i=%0d got=%b/%h want=%b/%h",
                         i, b1.rvalid, b1.rdata, v1, d1); bad++;
            end
        end
    endtask

    task automatic test_byte_en();
        bit          v;
        logic [31:0] d;
        logic [31:0] seen [$];
        for (int i = 0; i < 8; i++) begin
            unique case (i)
                0: issue1(1, 1, 6'd5, 32'hAABBCCDD, 4'b1111);
                1: issue1(1, 1, 6'd5, 32'h11223344, 4'b0101);
                2: issue1(1, 0, 6'd5, '0, 4'b0000);
                3: issue1(1, 1, 6'd6, 32'hFFFFFFFF, 4'b0000);
                4: issue1(1, 0, 6'd6, '0, 4'b1111);
                default: issue1(0, 0, '0, '0, '0);
            endcase
            tick();
            exp1(v, d);
            if (b1.rvalid === 1'b1) seen.push_back(b1.rdata);
            total++;
            if (b1.rvalid !== v || b1.rdata !== d) begin
                $display("FAIL be_model i=%0d got=%b/%h want=%b/%h",
                         i, b1.rvalid, b1.rdata, v, d); bad++;
            end
        end
        total += 3;
        if (seen.size() != 2) begin
            $display("FAIL be_count got=%0d want=2", seen.size());
            bad++;
        end else begin
            if (seen[0] !== 32'hAA22CC44) begin
                $display("FAIL be_merge got=%h want=AA22CC44",
                         seen[0]); bad++;
            end
            if (seen[1] !== CV1) begin
                $display("FAIL be_zero got=%h want=%h",
                         seen[1], CV1); bad++;
            end
        end
    endtask

    task automatic test_latency();
        bit          v;
        logic [31:0] d;
        for (int i = 1; i <= 3; i++) begin
            issue1(1, 1, 6'(i), 32'(i), 4'b1111);
            tick();
            exp1(v, d);
        end
        for (int t = 0; t < 5; t++) begin
            if (t < 3) issue1(1, 0, 6'(t + 1), '0, '0);
            else issue1(0, 0, '0, '0, '0);
            tick();
            exp1(v, d);
            total++;
            if (b1.rvalid !== (t >= 1 && t <= 3)) begin
                $display("FAIL lat_rvalid t=%0d got=%b want=%b",
                         t, b1.rvalid, t >= 1 && t <= 3); bad++;
            end
            if (t >= 1 && t <= 3) begin
                total++;
                if (b1.rdata !== 32'(t)) begin
                    $display("FAIL lat_rdata t=%0d got=%h want=%h",
                             t, b1.rdata, 32'(t)); bad++;
                end
            end
        end
    endtask

    task automatic test_oor();
        bit          v;
        logic [31:0] d;
        logic [31:0] seen [$];
        for (int i = 0; i < 5; i++) begin
            unique case (i)
                0: issue1(1, 1, 6'd50, 32'h77, 4'b1111);
                1: issue1(1, 0, 6'd50, '0, '0);
                2: issue1(1, 0, 6'd47, '0, '0);
                default: issue1(0, 0, '0, '0, '0);
            endcase
            tick();
            exp1(v, d);
            if (b1.rvalid === 1'b1) seen.push_back(b1.rdata);
        end
        total += 3;
        if (seen.size() != 2) begin
            $display("FAIL oor_count got=%0d want=2", seen.size());
            bad++;
        end else begin
            if (seen[0] !== 32'h0) begin
                $display("FAIL oor_read got=%h want=0", seen[0]);
                bad++;
            end
            if (seen[1] !== CV1) begin
                $display("FAIL oor_last got=%h want=%h",
                         seen[1], CV1); bad++;
            end
        end
    endtask

    task automatic test_random();
        bit          v0, v1;
        logic [7:0]  d0;
        logic [31:0] d1;
        logic [5:0]  a;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom % 2 == 1) ? 6'($urandom % 8)
                                    : 6'($urandom % 64);
            issue0($urandom % 4 != 0, $urandom % 2 == 1, a,
                   8'($urandom), 1'($urandom));
            a = ($urandom % 2 == 1) ? 6'($urandom % 8)
                                    : 6'($urandom % 64);
            issue1($urandom % 4 != 0, $urandom % 2 == 1, a,
                   $urandom, 4'($urandom));
            tick();
            exp0(v0, d0);
            exp1(v1, d1);
            total += 2;
            if (b0.rvalid !== v0 || b0.rdata !== d0) begin
                $display("FAIL rand0 i=%0d got=%b/%h want=%b/%h",
                         i, b0.rvalid, b0.rdata, v0, d0); bad++;
            end
            if (b1.rvalid !== v1 || b1.rdata !== d1) begin
                $display("FAIL rand1 i=%0d got=%b/%h want=%b/%h",
                         i, b1.rvalid, b1.rdata, v1, d1); bad++;
            end
        end
        issue0(0, 0, '0, '0, '0);
        issue1(0, 0, '0, '0, '0);
        tick();
        tick();
        due0.delete();
        due1.delete();
    endtask

    task automatic test_reset_midop();
        issue0(1, 1, 6'd10, 8'h5A, 1'b1);
        issue1(1, 0, 6'd3, '0, '0);
        tick();
        total++;
        if (b1.rvalid !== 1'b0) begin
            $display("FAIL mid_early1 got=%b want=0", b1.rvalid);
            bad++;
        end
        rst0 = 1; rst1 = 1;
        issue0(1, 0, 6'd10, '0, '0);
        issue1(0, 0, '0, '0, '0);
        tick();
        model_reset();
        total += 2;
        if (b0.rvalid !== 1'b0 || b1.rvalid !== 1'b0) begin
            $display("FAIL mid_rvalid got=%b/%b want=0/0",
                     b0.rvalid, b1.rvalid); bad++;
        end
        if (b0.rdata !== 8'h00 || b1.rdata !== 32'h0) begin
            $display("FAIL mid_rdata got=%h/%h want=0/0",
                     b0.rdata, b1.rdata); bad++;
        end
        rst0 = 0; rst1 = 0;
        issue0(0, 0, '0, '0, '0);
        for (int k = 1; k <= 64; k++) begin
            tick();
            total += 2;
            if (b0.ready !== (k >= 64) || b1.ready !== (k >= 48)) begin
                $display("FAIL mid_ready k=%0d got=%b/%b want=%b/%b",
                         k, b0.ready, b1.ready, k >= 64, k >= 48);
                bad++;
            end
            if (b0.rvalid !== 1'b0 || b1.rvalid !== 1'b0) begin
                $display("FAIL mid_clr_rvalid k=%0d got=%b/%b want=0/0",
                         k, b0.rvalid, b1.rvalid); bad++;
            end
        end
        model_cleared();
        issue0(1, 0, 6'd10, '0, '0);
        issue1(1, 0, 6'd3, '0, '0);
        tick();
        issue0(0, 0, '0, '0, '0);
        issue1(0, 0, '0, '0, '0);
        total++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== 8'h00) begin
            $display("FAIL mid_reread0 got=%b/%h want=1/00",
                     b0.rvalid, b0.rdata); bad++;
        end
        tick();
        total++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== CV1) begin
            $display("FAIL mid_reread1 got=%b/%h want=1/%h",
                     b1.rvalid, b1.rdata, CV1); bad++;
        end
        due0.delete();
        due1.delete();
    endtask

    initial begin
        cyc = 0; total = 0; bad = 0;
        test_reset();
        test_clear();
        test_sweep();
        test_byte_en();
        test_latency();
        test_oor();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
